// File: rtl/dispatch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : dispatch_pkg                                                     |
// | Brief    : Shared types and instruction layout for the device dispatcher.   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package dispatch_pkg;

   // Instruction word layout: {data[15:0], addr[7:0], op[3:0], dev_no[3:0]}
   localparam int c_INSTR_W  = 32;
   localparam int c_DEV_LSB  = 0;
   localparam int c_DEV_W    = 4;
   localparam int c_OP_LSB   = 4;
   localparam int c_OP_W     = 4;
   localparam int c_ADDR_LSB = 8;
   localparam int c_ADDR_W   = 8;
   localparam int c_DATA_LSB = 16;
   localparam int c_DATA_W   = 16;

   localparam int c_ADC_W    = 14;
   localparam int c_CNT_W    = 16;
   localparam int c_ERR_W    = 2;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_FETCH      = 3'd1,
      ST_WAIT_VALID = 3'd2,
      ST_ISSUE      = 3'd3,
      ST_GUARD      = 3'd4,
      ST_WAIT_RDY   = 3'd5,
      ST_WRITE      = 3'd6,
      ST_ERROR      = 3'd7
   } state_e;

   typedef enum logic [c_DEV_W-1:0] {
      DEV_NOP   = 4'd0,
      DEV_ADC   = 4'd1,
      DEV_DAC   = 4'd2,
      DEV_TIMER = 4'd3,
      DEV_SW0   = 4'd4,
      DEV_SW1   = 4'd5,
      DEV_SW2   = 4'd6
   } dev_e;

   typedef enum logic [c_ERR_W-1:0] {
      ERR_NONE     = 2'b00,
      ERR_TIMEOUT  = 2'b01,
      ERR_ILLEGAL  = 2'b10,
      ERR_OVERFLOW = 2'b11
   } err_e;

endpackage
`default_nettype wire

// File: rtl/device_dispatcher_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : device_dispatcher_if                                             |
// | Brief    : Instruction source, device bus and output FIFO signal bundle.    |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
interface device_dispatcher_if #(
   parameter int NUM_DEV = 7
);
   import dispatch_pkg::*;

   logic                  en;
   logic                  instr_empty;
   logic                  instr_read;
   logic                  instr_valid;
   logic [c_INSTR_W-1:0]  instr;
   logic [NUM_DEV-1:0]    dev_cs;
   logic [NUM_DEV-1:0]    dev_rdy;
   logic [c_OP_W-1:0]     op_bus;
   logic [c_ADDR_W-1:0]   addr_bus;
   logic [c_DATA_W-1:0]   data_bus;
   logic [c_ADC_W-1:0]    adc_data;
   logic                  out_wr;
   logic [c_DATA_W-1:0]   out_data;
   logic                  out_full;
   logic                  busy;
   logic                  err;
   logic [c_ERR_W-1:0]    err_code;
   logic [c_CNT_W-1:0]    instr_count;

   modport master (
      input  en, instr_empty, instr_valid, instr, dev_rdy, adc_data, out_full,
      output instr_read, dev_cs, op_bus, addr_bus, data_bus, out_wr, out_data,
             busy, err, err_code, instr_count
   );

   modport slave (
      output en, instr_empty, instr_valid, instr, dev_rdy, adc_data, out_full,
      input  instr_read, dev_cs, op_bus, addr_bus, data_bus, out_wr, out_data,
             busy, err, err_code, instr_count
   );

endinterface
`default_nettype wire

// File: rtl/dispatch_watchdog.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : dispatch_watchdog                                                |
// | Brief    : Loadable up-counter with clear/enable and a terminal flag.       |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module dispatch_watchdog #(
   parameter int WIDTH = 16,
   parameter int LIMIT = 65535
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clear,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic             i_enable,
   output logic             o_terminal
);

   logic [WIDTH-1:0] r_count;

   // Holds at the terminal value so the flag stays up until cleared.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_enable && !o_terminal) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

   assign o_terminal = (r_count == WIDTH'(LIMIT));

endmodule
`default_nettype wire

// File: rtl/device_dispatcher.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : device_dispatcher                                                |
// | Brief    : Fetches instruction words, issues device selects, waits on ready |
// |            under a watchdog and forwards ADC results to the output FIFO.    |
// |            DEVICE_DISPATCHER_TAG_EN prefixes each ADC word with a tag word. |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module device_dispatcher
   import dispatch_pkg::*;
#(
   parameter int NUM_DEV        = 7,
   parameter int TIMEOUT_CYCLES = 65535,
   parameter int RDY_GUARD      = 2
) (
   input  logic                clk,
   input  logic                rst,
   device_dispatcher_if.master bus
);

   localparam int c_WD_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int c_GUARD_W = (RDY_GUARD > 1) ? $clog2(RDY_GUARD) : 1;

   state_e                 r_state;
   state_e                 w_state_nxt;
   err_e                   r_err_code;
   err_e                   w_err_code_nxt;
   logic [c_DEV_W-1:0]     r_dev;
   logic [c_OP_W-1:0]      r_op;
   logic [c_ADDR_W-1:0]    r_addr;
   logic [c_DATA_W-1:0]    r_data;
   logic [c_CNT_W-1:0]     r_count;
   logic [c_GUARD_W-1:0]   r_guard_cnt;

   logic                   w_latch;
   logic                   w_count_inc;
   logic                   w_wd_restart;
   logic                   w_wd_clear;
   logic                   w_wd_en;
   logic                   w_wd_term;
   logic [c_DEV_W-1:0]     w_in_dev;
   logic [NUM_DEV-1:0]     w_dev_onehot;
   logic                   w_dev_rdy;
   logic                   w_out_wr;
   logic [c_DATA_W-1:0]    w_adc_word;

`ifdef DEVICE_DISPATCHER_TAG_EN
   logic                   r_beat;
   logic                   w_beat_nxt;
`endif

   assign w_in_dev     = bus.instr[c_DEV_LSB +: c_DEV_W];
   assign w_dev_onehot = {{(NUM_DEV-1){1'b0}}, 1'b1} << r_dev;
   assign w_dev_rdy    = |(bus.dev_rdy & w_dev_onehot);
   assign w_out_wr     = (r_state == ST_WRITE) && !bus.out_full;
   assign w_adc_word   = {{(c_DATA_W-c_ADC_W){1'b0}}, bus.adc_data};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ERROR has no exit, so the IDLE check need not test the error flag.
   always_comb begin
      w_state_nxt    = r_state;
      w_err_code_nxt = r_err_code;
      w_latch        = 1'b0;
      w_count_inc    = 1'b0;
      w_wd_restart   = 1'b0;
`ifdef DEVICE_DISPATCHER_TAG_EN
      w_beat_nxt     = r_beat;
`endif
      case (r_state)
         ST_IDLE: begin
            if (bus.en && !bus.instr_empty) begin
               w_state_nxt = ST_FETCH;
            end
         end
         ST_FETCH: begin
            w_state_nxt = ST_WAIT_VALID;
         end
         ST_WAIT_VALID: begin
            if (bus.instr_valid) begin
               w_latch = 1'b1;
               if (int'(w_in_dev) >= NUM_DEV) begin
                  w_state_nxt    = ST_ERROR;
                  w_err_code_nxt = ERR_ILLEGAL;
               end else if (w_in_dev == DEV_NOP) begin
                  w_count_inc = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            w_state_nxt = (RDY_GUARD == 0) ? ST_WAIT_RDY : ST_GUARD;
         end
         ST_GUARD: begin
            if (r_guard_cnt == c_GUARD_W'(RDY_GUARD - 1)) begin
               w_state_nxt = ST_WAIT_RDY;
            end
         end
         ST_WAIT_RDY: begin
            if (w_dev_rdy) begin
               if (r_dev == DEV_ADC) begin
                  w_wd_restart = 1'b1;
                  w_state_nxt  = ST_WRITE;
               end else begin
                  w_count_inc = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end else if (w_wd_term) begin
               w_state_nxt    = ST_ERROR;
               w_err_code_nxt = ERR_TIMEOUT;
            end
         end
         ST_WRITE: begin
            if (!bus.out_full) begin
`ifdef DEVICE_DISPATCHER_TAG_EN
               if (!r_beat) begin
                  w_beat_nxt   = 1'b1;
                  w_wd_restart = 1'b1;
               end else begin
                  w_count_inc = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
`else
               w_count_inc = 1'b1;
               w_state_nxt = ST_IDLE;
`endif
            end else if (w_wd_term) begin
               w_state_nxt    = ST_ERROR;
               w_err_code_nxt = ERR_OVERFLOW;
            end
         end
         ST_ERROR: begin
            w_state_nxt = ST_ERROR;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dev       <= '0;
         r_op        <= '0;
         r_addr      <= '0;
         r_data      <= '0;
         r_count     <= '0;
         r_err_code  <= ERR_NONE;
         r_guard_cnt <= '0;
      end else begin
         if (w_latch) begin
            r_dev  <= w_in_dev;
            r_op   <= bus.instr[c_OP_LSB   +: c_OP_W];
            r_addr <= bus.instr[c_ADDR_LSB +: c_ADDR_W];
            r_data <= bus.instr[c_DATA_LSB +: c_DATA_W];
         end
         if (w_count_inc) begin
            r_count <= r_count + c_CNT_W'(1);
         end
         r_err_code <= w_err_code_nxt;
         if (r_state == ST_ISSUE) begin
            r_guard_cnt <= '0;
         end else if (r_state == ST_GUARD) begin
            r_guard_cnt <= r_guard_cnt + c_GUARD_W'(1);
         end
      end
   end

`ifdef DEVICE_DISPATCHER_TAG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat <= 1'b0;
      end else begin
         r_beat <= (w_state_nxt == ST_WRITE) ? w_beat_nxt : 1'b0;
      end
   end
`endif

   // Restarted on entry to WAIT_RDY / WRITE and again for each write beat.
   assign w_wd_en    = (r_state == ST_WAIT_RDY) || (r_state == ST_WRITE);
   assign w_wd_clear = !w_wd_en || w_wd_restart;

   dispatch_watchdog #(
      .WIDTH (c_WD_W),
      .LIMIT (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (w_wd_clear),
      .i_load     (1'b0),
      .i_load_val ({c_WD_W{1'b0}}),
      .i_enable   (w_wd_en),
      .o_terminal (w_wd_term)
   );

   assign bus.instr_read  = (r_state == ST_FETCH);
   assign bus.dev_cs      = (r_state == ST_ISSUE) ? w_dev_onehot : '0;
   assign bus.op_bus      = r_op;
   assign bus.addr_bus    = r_addr;
   assign bus.data_bus    = r_data;
   assign bus.out_wr      = w_out_wr;
`ifdef DEVICE_DISPATCHER_TAG_EN
   assign bus.out_data    = !w_out_wr ? '0 :
                            r_beat    ? w_adc_word :
                                        {r_dev, r_count[c_DATA_W-c_DEV_W-1:0]};
`else
   assign bus.out_data    = w_out_wr ? w_adc_word : '0;
`endif
   assign bus.busy        = (r_state != ST_IDLE);
   assign bus.err         = (r_state == ST_ERROR);
   assign bus.err_code    = r_err_code;
   assign bus.instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_device_dispatcher.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_device_dispatcher                                             |
// | Brief    : Directed self-checking bench for device_dispatcher.              |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_device_dispatcher;

   localparam int NUM_DEV = 7;
   localparam int TIMEOUT = 16;
   localparam int GUARD   = 2;
`ifdef DEVICE_DISPATCHER_TAG_EN
   localparam int c_WR_PER_ADC = 2;
`else
   localparam int c_WR_PER_ADC = 1;
`endif

   logic clk = 1'b0;
   logic rst;

   device_dispatcher_if #(.NUM_DEV(NUM_DEV)) bus ();

   device_dispatcher #(
      .NUM_DEV        (NUM_DEV),
      .TIMEOUT_CYCLES (TIMEOUT),
      .RDY_GUARD      (GUARD)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int n_read   = 0;
   int n_cs     = 0;
   int n_wr     = 0;
   int cs_bad   = 0;
   int t_fetch  = 0;
   logic [15:0]        wr_last = '0;
   logic [15:0]        wr_prev = '0;
   logic [NUM_DEV-1:0] cs_prev = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Event log sampled mid-cycle; also flags wide or multi-bit chip selects.
   always @(negedge clk) begin
      if (bus.instr_read) n_read <= n_read + 1;
      if (|bus.dev_cs)    n_cs   <= n_cs + 1;
      if (($countones(bus.dev_cs) > 1) || ((|cs_prev) && (|bus.dev_cs))) cs_bad <= cs_bad + 1;
      cs_prev <= bus.dev_cs;
      if (bus.out_wr) begin
         n_wr    <= n_wr + 1;
         wr_prev <= wr_last;
         wr_last <= bus.out_data;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_instr(input logic [31:0] w);
      logic seen;
      seen = 1'b0;
      bus.instr_empty = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         step();
         seen = bus.instr_read;
      end
      t_fetch = cyc;
      bus.instr_empty = 1'b1;
      check_eq("fetch_pulse", {31'd0, seen}, 32'd1);
      step();
      bus.instr       = w;
      bus.instr_valid = 1'b1;
      step();
      bus.instr_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      for (int i = 0; i < max && bus.busy; i++) step();
      check_eq("idle_reached", {31'd0, bus.busy}, 32'd0);
   endtask

   task automatic wait_err(input int max);
      for (int i = 0; i < max && !bus.err; i++) step();
      check_eq("err_reached", {31'd0, bus.err}, 32'd1);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
      check_eq({tag, "_err"},   {31'd0, bus.err}, 32'd0);
      check_eq({tag, "_code"},  {30'd0, bus.err_code}, 32'd0);
      check_eq({tag, "_count"}, {16'd0, bus.instr_count}, 32'd0);
      check_eq({tag, "_buses"}, {4'd0, bus.op_bus, bus.addr_bus, bus.data_bus}, 32'd0);
      check_eq({tag, "_cs"},    {25'd0, bus.dev_cs}, 32'd0);
      check_eq({tag, "_strb"},  {30'd0, bus.out_wr, bus.instr_read}, 32'd0);
      check_eq({tag, "_odata"}, {16'd0, bus.out_data}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: observed no finish expected finish");
      $fatal(1);
   end

   initial begin
      int b_cs, b_wr, b_rd;
      bus.en          = 1'b1;
      bus.instr_empty = 1'b1;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      bus.dev_rdy     = 7'b0000001;
      bus.adc_data    = '0;
      bus.out_full    = 1'b0;
      rst = 1'b1;
      step();
      step();
      check_all_zero("reset");
      rst = 1'b0;

      // en low keeps the block parked in IDLE
      bus.en = 1'b0;
      bus.instr_empty = 1'b0;
      b_rd = n_read;
      repeat (5) step();
      check_eq("en_gate_reads", n_read - b_rd, 0);
      check_eq("en_gate_busy", {31'd0, bus.busy}, 32'd0);
      bus.instr_empty = 1'b1;
      bus.en = 1'b1;

      // three NOPs
      for (int k = 0; k < 3; k++) do_instr(32'hABCD_1230);
      check_eq("nop_count", {16'd0, bus.instr_count}, 32'd3);
      check_eq("nop_data_bus", {16'd0, bus.data_bus}, 32'hABCD);

      // DAC write, ready low for 5 cycles after the guard
      b_cs = n_cs; b_wr = n_wr; b_rd = n_read;
      do_instr(32'h1234_0512);
      check_eq("dac_cs", {25'd0, bus.dev_cs}, 32'h04);
      check_eq("dac_data_bus", {16'd0, bus.data_bus}, 32'h1234);
      check_eq("dac_addr_bus", {24'd0, bus.addr_bus}, 32'h05);
      check_eq("dac_op_bus", {28'd0, bus.op_bus}, 32'h1);
      repeat (3) step();
      repeat (5) step();
      check_eq("dac_waiting", {31'd0, bus.busy}, 32'd1);
      bus.dev_rdy[2] = 1'b1;
      step();
      bus.dev_rdy[2] = 1'b0;
      check_eq("dac_idle", {31'd0, bus.busy}, 32'd0);
      check_eq("dac_count", {16'd0, bus.instr_count}, 32'd4);
      check_eq("dac_cs_pulses", n_cs - b_cs, 1);
      check_eq("dac_no_wr", n_wr - b_wr, 0);
      check_eq("dac_reads", n_read - b_rd, 1);

      // minimum latency with ready held high through the guard
      bus.dev_rdy[2] = 1'b1;
      do_instr(32'h0042_0732);
      wait_idle(20);
      bus.dev_rdy[2] = 1'b0;
      check_eq("dac_min_latency", cyc - t_fetch, 6);
      check_eq("dac2_count", {16'd0, bus.instr_count}, 32'd5);
      check_eq("dac2_buses", {4'd0, bus.op_bus, bus.addr_bus, bus.data_bus}, 32'h0307_0042);

      // ADC read, ready after 3 cycles
      bus.adc_data = 14'h2ABC;
      b_wr = n_wr;
      do_instr(32'h0000_0001);
      repeat (6) step();
      bus.dev_rdy[1] = 1'b1;
      step();
      bus.dev_rdy[1] = 1'b0;
      wait_idle(10);
      check_eq("adc_writes", n_wr - b_wr, c_WR_PER_ADC);
      check_eq("adc_data", {16'd0, wr_last}, 32'h2ABC);
`ifdef DEVICE_DISPATCHER_TAG_EN
      check_eq("adc_tag", {16'd0, wr_prev}, 32'h1005);
`endif
      check_eq("adc_count", {16'd0, bus.instr_count}, 32'd6);

      // backpressure: out_full for 10 write cycles
      bus.adc_data   = 14'h0123;
      bus.out_full   = 1'b1;
      bus.dev_rdy[1] = 1'b1;
      b_wr = n_wr;
      do_instr(32'h0000_0001);
      repeat (4) step();
      bus.dev_rdy[1] = 1'b0;
      repeat (9) step();
      check_eq("bp_held_wr", n_wr - b_wr, 0);
      check_eq("bp_held_busy", {31'd0, bus.busy}, 32'd1);
      bus.out_full = 1'b0;
      wait_idle(10);
      check_eq("bp_writes", n_wr - b_wr, c_WR_PER_ADC);
      check_eq("bp_data", {16'd0, wr_last}, 32'h0123);
`ifdef DEVICE_DISPATCHER_TAG_EN
      check_eq("bp_tag", {16'd0, wr_prev}, 32'h1006);
`else
      check_eq("bp_prev_data", {16'd0, wr_prev}, 32'h2ABC);
`endif
      check_eq("bp_count", {16'd0, bus.instr_count}, 32'd7);

      // ready arriving on the expiry cycle completes normally
      do_instr(32'h0000_0003);
      repeat (3) step();
      repeat (TIMEOUT) step();
      bus.dev_rdy[3] = 1'b1;
      step();
      bus.dev_rdy[3] = 1'b0;
      check_eq("expiry_tie_err", {31'd0, bus.err}, 32'd0);
      check_eq("expiry_tie_count", {16'd0, bus.instr_count}, 32'd8);

      // timeout on device 3
      b_rd = n_read;
      do_instr(32'h0000_0003);
      wait_err(40);
      check_eq("timeout_latency", cyc - t_fetch, 22);
      check_eq("timeout_code", {30'd0, bus.err_code}, 32'd1);
      bus.instr_empty = 1'b0;
      repeat (20) step();
      check_eq("timeout_no_fetch", n_read - b_rd, 1);
      check_eq("timeout_sticky", {31'd0, bus.err}, 32'd1);
      bus.instr_empty = 1'b1;
      pulse_reset();
      check_eq("timeout_rst_err", {31'd0, bus.err}, 32'd0);
      check_eq("timeout_rst_count", {16'd0, bus.instr_count}, 32'd0);

      // illegal device, then recovery
      b_cs = n_cs;
      do_instr(32'h0000_0009);
      check_eq("illegal_err", {31'd0, bus.err}, 32'd1);
      check_eq("illegal_code", {30'd0, bus.err_code}, 32'd2);
      check_eq("illegal_no_cs", n_cs - b_cs, 0);
      pulse_reset();
      check_eq("illegal_rst_err", {29'd0, bus.err, bus.err_code}, 32'd0);
      do_instr(32'h0000_0000);
      check_eq("resume_count", {16'd0, bus.instr_count}, 32'd1);

      // overflow: out_full never releases
      bus.out_full   = 1'b1;
      bus.dev_rdy[1] = 1'b1;
      b_wr = n_wr;
      do_instr(32'h0000_0001);
      wait_err(40);
      bus.dev_rdy[1] = 1'b0;
      check_eq("overflow_code", {30'd0, bus.err_code}, 32'd3);
      check_eq("overflow_no_wr", n_wr - b_wr, 0);
      bus.out_full = 1'b0;
      pulse_reset();

      // NOP stream, then reset in the middle of WAIT_RDY
      for (int k = 0; k < 3; k++) do_instr(32'h0000_0000);
      check_eq("stream_count", {16'd0, bus.instr_count}, 32'd3);
      b_cs = n_cs;
      do_instr(32'h5555_6672);
      repeat (4) step();
      rst = 1'b1;
      step();
      check_all_zero("midrst");
      rst = 1'b0;
      step();
      check_eq("midrst_cs_total", n_cs - b_cs, 1);
      check_eq("cs_onehot_single", cs_bad, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
